iq_dispatch_ctrl: RTL
=====================

Name: iq_dispatch_ctrl

Overview:
- Sequences the instruction queue's dequeue port and presents one instruction per cycle to rename/dispatch.
- Classifies each instruction to one of four reservation-station (RS) classes, holds it until the ROB and the target RS both have space, and propagates pipeline flush to the queue.
- Sits between the fetch-side instruction queue and the ROB/RS allocation logic.

Parameters:
- INST_WIDTH, 32, width of the queue entry (instruction word).
- PERF_CNT_WIDTH, 32, width of the optional stall counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  backend redirect; kills the in-flight/held instruction
- iq_empty  in  1  queue empty flag
- iq_dequeue  out  1  dequeue request to queue (combinational)
- iq_flush  out  1  flush to queue; equals flush
- iq_rdata  in  INST_WIDTH  queue read data, valid the cycle after iq_dequeue
- rob_ready  in  1  ROB can allocate one entry this cycle
- rs_ready  in  4  per-class RS has a free entry: [0]=ALU [1]=MULDIV [2]=LSU [3]=BR
- dispatch_valid  out  1  dispatch_inst is valid
- dispatch_inst  out  INST_WIDTH  instruction being dispatched
- dispatch_rs_sel  out  4  one-hot target RS; zero when dispatch_valid=0
- rob_alloc  out  1  allocate strobe = dispatch accepted this cycle

Behaviour:
- Asynchronous reset: state=IDLE, inst_reg=0; every output is 0.
- FSM states: IDLE (nothing in flight), PEND (dequeue issued last cycle; iq_rdata valid now), HELD (instruction latched in inst_reg, awaiting resources).
- accept = dispatch_valid & rob_ready & rs_ready[class]. rob_alloc = accept. dispatch_rs_sel = onehot(class) & {4{dispatch_valid}}.
- Classification uses opcode bits [6:0]:
  - LOAD/STORE -> LSU.
  - BRANCH/JAL/JALR -> BR.
  - OP with funct7=0000001 -> MULDIV.
  - Everything else -> ALU.
- IDLE: dispatch_valid=0. If !iq_empty: iq_dequeue=1, next state PEND.
- PEND: dispatch_valid=1 and dispatch_inst=iq_rdata.
  - If accept and !iq_empty: iq_dequeue=1, stay in PEND. This gives back-to-back throughput of 1 per cycle.
  - If accept and iq_empty: go to IDLE.
  - If !accept: latch iq_rdata into inst_reg and go to HELD.
- HELD: dispatch_valid=1 and dispatch_inst=inst_reg.
  - If accept: dequeue if !iq_empty (then go to PEND), else go to IDLE.
  - If !accept: hold state; dispatch_inst is stable.
- iq_dequeue is never asserted while iq_empty=1, and never in a cycle without accept except from IDLE.
- Latency: an instruction enqueued into an empty, idle queue is dispatchable 2 cycles after enqueue (1-cycle queue read latency plus the IDLE->PEND step).
- flush has priority over everything:
  - iq_flush=1, dispatch_valid=0, rob_alloc=0, iq_dequeue=0 in that cycle.
  - Next state is IDLE and inst_reg is cleared.
  - A PEND instruction arriving in the flush cycle is discarded.
- Reset asserted mid-operation returns the block to IDLE immediately (asynchronous); no dispatch is lost or duplicated because the queue is flushed too.
- Resource readiness is sampled combinationally; no speculation on rs_ready changing.

Optional Feature:
- Macro: IQ_DISPATCH_PERF_CNT_EN.
- Enabled: adds outputs perf_rob_stall, perf_rs_stall and perf_empty_cycles, each PERF_CNT_WIDTH wide.
  - perf_rob_stall increments on dispatch_valid & !rob_ready.
  - perf_rs_stall increments on dispatch_valid & rob_ready & !rs_ready[class].
  - perf_empty_cycles increments in IDLE with iq_empty.
  - Counters saturate at all-ones, clear on rst, and are unaffected by flush.
- Disabled: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- rv32i_types gets:
  - enum rs_class_t {RS_ALU, RS_MULDIV, RS_LSU, RS_BR}.
  - enum iq_disp_state_t {IQD_IDLE, IQD_PEND, IQD_HELD}.
  - Opcode constants (already present).
- Sub-module inst_classify: a combinational opcode/funct7 -> rs_class_t decoder, reused later by rename.

Test Plan:
- Queue holds ADD, LW, BEQ; all ready -> dequeue at cycles 0,1,2; dispatch_valid at 1,2,3 with rs_sel 0001, 0100, 1000; rob_alloc each cycle.
- MUL (funct7=0000001), rs_ready=4'b1101 for 3 cycles then 1111 -> PEND->HELD; dispatch_inst stable; no dequeue for 3 cycles; accept on cycle 4 with rs_sel 0010.
- rob_ready=0 with queue non-empty -> at most one dequeue issued; HELD persists; release -> one rob_alloc pulse, then streaming resumes.
- flush asserted in a PEND cycle with a valid LW -> dispatch_valid=0, iq_flush=1, state IDLE next; LW is never dispatched.
- rst asserted asynchronously mid-HELD -> outputs 0 before the next clk edge; after release, empty queue -> state stays IDLE with no dequeue.
- With IQ_DISPATCH_PERF_CNT_EN: 5 ROB-stall cycles and 2 RS-stall cycles -> perf_rob_stall=5, perf_rs_stall=2; preload all-ones -> counter stays saturated.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I decode types and opcode constants.
// Contents: opcode/funct7 constants, reservation-station class enum,
// dispatch FSM state enum, RS one-hot helper.
package rv32i_types;

    localparam int unsigned RS_NUM = 4;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        RS_ALU    = 2'd0,
        RS_MULDIV = 2'd1,
        RS_LSU    = 2'd2,
        RS_BR     = 2'd3
    } rs_class_t;

    typedef enum logic [1:0] {
        IQD_IDLE = 2'd0,
        IQD_PEND = 2'd1,
        IQD_HELD = 2'd2
    } iq_disp_state_t;

    // One-hot RS select for a class: bit index equals the enum encoding.
    function automatic logic [RS_NUM-1:0] rs_onehot(input rs_class_t c);
        return RS_NUM'(1) << c;
    endfunction

endpackage

// File: rtl/inst_classify.sv
// Combinational instruction classifier: opcode/funct7 -> reservation-station class.
// Ports:
//   opcode     in  [6:0]  instruction bits [6:0]
//   funct7     in  [6:0]  instruction bits [31:25]
//   rs_class_c out        target RS class (ALU / MULDIV / LSU / BR)
module inst_classify
    import rv32i_types::*;
(
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    output rs_class_t  rs_class_c
);

    // Anything not explicitly recognised falls through to the ALU station.
    always_comb begin
        rs_class_c = RS_ALU;
        case (opcode)
            OPC_LOAD, OPC_STORE:             rs_class_c = RS_LSU;
            OPC_BRANCH, OPC_JAL, OPC_JALR:   rs_class_c = RS_BR;
            OPC_OP: begin
                if (funct7 == FUNCT7_MULDIV) begin
                    rs_class_c = RS_MULDIV;
                end
            end
            default:                         rs_class_c = RS_ALU;
        endcase
    end

endmodule

// File: rtl/iq_dispatch_ctrl.sv
// Instruction-queue dispatch controller.
// Dequeues the instruction queue, presents one instruction per cycle to
// rename/dispatch, steers it to one of four RS classes and holds it until
// both the ROB and the target RS can accept it. Flush kills anything in flight.
// Optional macro IQ_DISPATCH_PERF_CNT_EN adds saturating stall counters.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               backend redirect
//   iq_empty            queue empty flag
//   iq_dequeue          dequeue request (combinational)
//   iq_flush            flush forwarded to queue (combinational)
//   iq_rdata            queue data, valid the cycle after iq_dequeue
//   rob_ready           ROB can allocate one entry
//   rs_ready[3:0]       per-class RS space: ALU, MULDIV, LSU, BR
//   dispatch_valid      dispatch_inst valid
//   dispatch_inst       instruction presented to dispatch
//   dispatch_rs_sel     one-hot target RS, zero when not valid
//   rob_alloc           dispatch accepted this cycle
//   perf_*              (macro only) ROB stall, RS stall and idle-empty counters
module iq_dispatch_ctrl
    import rv32i_types::*;
#(
    parameter int unsigned INST_WIDTH     = 32,
    parameter int unsigned PERF_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      iq_empty,
    output logic                      iq_dequeue,
    output logic                      iq_flush,
    input  logic [INST_WIDTH-1:0]     iq_rdata,
    input  logic                      rob_ready,
    input  logic [RS_NUM-1:0]         rs_ready,
    output logic                      dispatch_valid,
    output logic [INST_WIDTH-1:0]     dispatch_inst,
    output logic [RS_NUM-1:0]         dispatch_rs_sel,
    output logic                      rob_alloc
`ifdef IQ_DISPATCH_PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] perf_rob_stall,
    output logic [PERF_CNT_WIDTH-1:0] perf_rs_stall,
    output logic [PERF_CNT_WIDTH-1:0] perf_empty_cycles
`endif
);

    // Classification reads instruction bits [31:25]; counters need at least one bit.
    if (INST_WIDTH < 32 || PERF_CNT_WIDTH == 0) begin : g_param_chk
        $error("iq_dispatch_ctrl: INST_WIDTH must be >= 32 and PERF_CNT_WIDTH > 0");
    end

    iq_disp_state_t          state_q, state_d;
    logic [INST_WIDTH-1:0]   inst_q, inst_d;
    logic [INST_WIDTH-1:0]   cand_inst_c;
    rs_class_t               rs_class_c;
    logic                    accept_c;

    // Candidate instruction: fresh queue data in PEND, latched copy otherwise.
    assign cand_inst_c = (state_q == IQD_PEND) ? iq_rdata : inst_q;

    inst_classify u_classify (
        .opcode     (cand_inst_c[6:0]),
        .funct7     (cand_inst_c[31:25]),
        .rs_class_c (rs_class_c)
    );

    assign accept_c = rob_ready & rs_ready[rs_class_c];
    assign iq_flush = flush;

    // State and held-instruction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IQD_IDLE;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
        end
    end

    // Next-state and dispatch handshake; flush overrides every other path.
    always_comb begin
        state_d         = state_q;
        inst_d          = inst_q;
        iq_dequeue      = 1'b0;
        dispatch_valid  = 1'b0;
        dispatch_inst   = '0;
        dispatch_rs_sel = '0;
        rob_alloc       = 1'b0;

        if (rst) begin
            state_d = IQD_IDLE;
            inst_d  = '0;
        end else if (flush) begin
            state_d = IQD_IDLE;
            inst_d  = '0;
        end else begin
            case (state_q)
                IQD_IDLE: begin
                    if (!iq_empty) begin
                        iq_dequeue = 1'b1;
                        state_d    = IQD_PEND;
                    end
                end
                IQD_PEND, IQD_HELD: begin
                    dispatch_valid  = 1'b1;
                    dispatch_inst   = cand_inst_c;
                    dispatch_rs_sel = rs_onehot(rs_class_c);
                    if (accept_c) begin
                        rob_alloc = 1'b1;
                        // Refill immediately so streaming runs at one per cycle.
                        if (!iq_empty) begin
                            iq_dequeue = 1'b1;
                            state_d    = IQD_PEND;
                        end else begin
                            state_d    = IQD_IDLE;
                        end
                    end else if (state_q == IQD_PEND) begin
                        // Queue data is only valid this cycle, so capture it.
                        inst_d  = iq_rdata;
                        state_d = IQD_HELD;
                    end
                end
                default: begin
                    state_d = IQD_IDLE;
                    inst_d  = '0;
                end
            endcase
        end
    end

`ifdef IQ_DISPATCH_PERF_CNT_EN
    logic [PERF_CNT_WIDTH-1:0] perf_rob_stall_q, perf_rob_stall_d;
    logic [PERF_CNT_WIDTH-1:0] perf_rs_stall_q, perf_rs_stall_d;
    logic [PERF_CNT_WIDTH-1:0] perf_empty_cycles_q, perf_empty_cycles_d;
    logic                      rob_stall_c, rs_stall_c, empty_c;

    assign rob_stall_c = dispatch_valid & ~rob_ready;
    assign rs_stall_c  = dispatch_valid & rob_ready & ~rs_ready[rs_class_c];
    assign empty_c     = (state_q == IQD_IDLE) & iq_empty;

    // Saturating increments; flush does not clear the counters.
    always_comb begin
        perf_rob_stall_d    = perf_rob_stall_q;
        perf_rs_stall_d     = perf_rs_stall_q;
        perf_empty_cycles_d = perf_empty_cycles_q;
        if (rob_stall_c && (perf_rob_stall_q != '1)) begin
            perf_rob_stall_d = perf_rob_stall_q + PERF_CNT_WIDTH'(1);
        end
        if (rs_stall_c && (perf_rs_stall_q != '1)) begin
            perf_rs_stall_d = perf_rs_stall_q + PERF_CNT_WIDTH'(1);
        end
        if (empty_c && (perf_empty_cycles_q != '1)) begin
            perf_empty_cycles_d = perf_empty_cycles_q + PERF_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_rob_stall_q    <= '0;
            perf_rs_stall_q     <= '0;
            perf_empty_cycles_q <= '0;
        end else begin
            perf_rob_stall_q    <= perf_rob_stall_d;
            perf_rs_stall_q     <= perf_rs_stall_d;
            perf_empty_cycles_q <= perf_empty_cycles_d;
        end
    end

    assign perf_rob_stall    = perf_rob_stall_q;
    assign perf_rs_stall     = perf_rs_stall_q;
    assign perf_empty_cycles = perf_empty_cycles_q;
`endif

endmodule
